// File: rtl/mem_access_unit_if.sv
// Data-bus handshake between the MEM-stage access unit (master) and data memory (slave).
// req/we/addr/wdata/wstrb are held by the master until a one-cycle ack returns rdata.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [3:0]        bus_wstrb;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: runs one req/ack bus transaction per access and
// stalls the pipeline until it completes; extends load data by RV32I width code.
//
// state | meaning
// IDLE  | waiting for a legal load/store in MEM; launches the bus request
// BUSY  | request outstanding on the bus, pipeline stalled until bus_ack
// DONE  | access finished, rdata_MEM valid, pipeline advances this cycle
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid_MEM,
  input  logic              req_we_MEM,
  input  logic [2:0]        req_funct3_MEM,
  input  logic [ADDR_W-1:0] req_addr_MEM,
  input  logic [DATA_W-1:0] req_wdata_MEM,
  output logic              mem_stall,
  output logic              misalign_MEM,
  output logic [DATA_W-1:0] rdata_MEM,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [3:0]        bus_wstrb_q;
  logic [DATA_W-1:0] rdata_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;

  logic              bad_align;
  logic              illegal;
  logic              flagged;
  logic              launch;
  logic [3:0]        st_strb;
  logic [DATA_W-1:0] st_data;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ld_ext;

  always_comb begin
    bad_align = 1'b0;
    illegal   = 1'b0;
    case (req_funct3_MEM)
      3'b001, 3'b101:         bad_align = req_addr_MEM[0];
      3'b010:                 bad_align = |req_addr_MEM[1:0];
      3'b011, 3'b110, 3'b111: illegal   = 1'b1;
      default:                ;
    endcase
  end

  assign flagged      = req_valid_MEM & (bad_align | illegal);
  assign launch       = (state == IDLE) & req_valid_MEM & ~flagged;
  // Both flags are gated by rstn so they read 0 while reset is held.
  assign misalign_MEM = rstn & (state == IDLE) & flagged;
  assign mem_stall    = rstn & (launch | (state == BUSY));

  always_comb begin
    st_strb = 4'b0000;
    st_data = '0;
    if (req_we_MEM) begin
      case (req_funct3_MEM[1:0])
        2'b00: begin
          st_strb = 4'b0001 << req_addr_MEM[1:0];
          st_data = {4{req_wdata_MEM[7:0]}};
        end
        2'b01: begin
          st_strb = 4'b0011 << req_addr_MEM[1:0];
          st_data = {2{req_wdata_MEM[15:0]}};
        end
        default: begin
          st_strb = 4'b1111;
          st_data = req_wdata_MEM;
        end
      endcase
    end
  end

  // Word accesses are always aligned, so off_q = 0 leaves the word unshifted.
  always_comb begin
    shifted = bus.bus_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_ext = {24'b0, shifted[7:0]};
      3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ld_ext = {16'b0, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= 4'b0000;
      rdata_q     <= '0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= req_we_MEM;
            bus_addr_q  <= {req_addr_MEM[ADDR_W-1:2], 2'b00};
            bus_wdata_q <= st_data;
            bus_wstrb_q <= st_strb;
            f3_q        <= req_funct3_MEM;
            off_q       <= req_addr_MEM[1:0];
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (bus.bus_ack) begin
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            if (!bus_we_q) rdata_q <= ld_ext;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          bus_req_q <= 1'b0;
          bus_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_wstrb = bus_wstrb_q;
  assign rdata_MEM     = rdata_q;

endmodule
